fetch_unit: RTL and testbench

Parametrised instruction-fetch front end with a reset vector, a single-outstanding imem request tracker, a redirect/squash mechanism and a small registered fetch buffer. It sits between the instruction memory port and the instruction queue/decode. It replaces the bare PC register with a block that decouples memory latency from decode back-pressure and discards responses that are stale after a redirect.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: reset vector, single-outstanding imem request tracking,
// redirect squash of stale responses and a small registered fetch buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          PW   = $clog2(DEPTH);
  localparam int          CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic push;
  logic pop;
  logic issue;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign imem_addr  = fetch_pc_q;
  assign imem_rmask = issue ? 4'hF : 4'h0;

  // A full buffer may still issue when its head leaves this cycle; the issue
  // reserves the slot its response will land in.
  always_comb begin
    pop   = inst_valid && inst_ready && !redirect_valid;
    push  = (state_q == ST_WAIT) && imem_resp && !redirect_valid;
    issue = !rst && !redirect_valid && (state_q == ST_IDLE) &&
            ((count_q < FULL) || (inst_valid && inst_ready));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_resp)           state_d = ST_IDLE;
        else if (redirect_valid) state_d = ST_DROP;
      end
      ST_DROP: if (imem_resp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect_valid)  fetch_pc_d = {redirect_pc[31:2], 2'b00};
    else if (push)       fetch_pc_d = req_pc_q + 32'd4;
    if (issue)           req_pc_d   = fetch_pc_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        inst_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= pc_mem_d[i];
        inst_mem_q[i] <= inst_mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model plus imem responder, directed
// scenarios with literal expectations, then a long randomized run.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h6000_0000;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_stale;
  bit          exp_issue;
  int          lat_left, lat_lo, lat_hi;
  bit          spur_en, force_en, rand_data;
  logic [31:0] force_data;
  int          checks, failures;
  int          n_iss;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Drive the memory for this cycle, let outputs settle, compare against the model.
  task automatic pre();
    if (m_out) begin
      if (lat_left == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = force_en ? force_data : (rand_data ? $urandom : data_of(m_req_pc));
      end else begin
        lat_left--;
        imem_resp  = 1'b0;
        imem_rdata = $urandom;
      end
    end else begin
      imem_resp  = spur_en && ($urandom_range(0, 7) == 0);
      imem_rdata = $urandom;
    end
    #1;
    exp_issue = !rst && !redirect_valid && !m_out &&
                ((mq.size() < DEPTH) || (inst_ready && mq.size() > 0));
    chk("imem_rmask", {28'd0, imem_rmask}, exp_issue ? 32'hF : 32'h0);
    chk("imem_addr", imem_addr, m_fetch_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("inst", inst, mq[0].ins);
      chk("inst_pc", inst_pc, mq[0].pc);
    end
  endtask

  // Apply the clock edge to the model using the inputs held during the cycle.
  task automatic advance();
    bit   pop_ok;
    ent_t e;
    pop_ok = inst_ready && (mq.size() > 0);
    @(posedge clk);
    if (rst) begin
      m_fetch_pc = RPC;
      m_out      = 1'b0;
      m_stale    = 1'b0;
      mq.delete();
    end else if (redirect_valid) begin
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      mq.delete();
      if (m_out) begin
        if (imem_resp) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (m_out && imem_resp) begin
        if (!m_stale) begin
          e.pc  = m_req_pc;
          e.ins = imem_rdata;
          mq.push_back(e);
          m_fetch_pc = m_req_pc + 32'd4;
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else if (exp_issue) begin
        m_out    = 1'b1;
        m_stale  = 1'b0;
        m_req_pc = m_fetch_pc;
        lat_left = $urandom_range(lat_hi, lat_lo);
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    pre();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0;
    lat_lo = 0; lat_hi = 0; lat_left = 0;
    spur_en = 1'b0; force_en = 1'b0; rand_data = 1'b0; force_data = '0;
    m_fetch_pc = RPC; m_req_pc = RPC; m_out = 1'b0; m_stale = 1'b0;

    @(posedge clk);
    @(negedge clk);

    // Reset values
    pre();
    chk("rst_rmask", {28'd0, imem_rmask}, 32'h0);
    chk("rst_addr", imem_addr, 32'h6000_0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    advance();

    // 1-cycle memory, no back-pressure: one request every 2 cycles
    rst = 1'b0; inst_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      pre();
      if (c == 0) begin
        chk("p1_rmask0", {28'd0, imem_rmask}, 32'hF);
        chk("p1_addr0", imem_addr, 32'h6000_0000);
      end
      if (c == 1) chk("p1_gap", {28'd0, imem_rmask}, 32'h0);
      if (c == 2) begin
        chk("p1_addr1", imem_addr, 32'h6000_0004);
        chk("p1_inst_pc0", inst_pc, 32'h6000_0000);
        chk("p1_inst0", inst, 32'h3A5A_5A5A);
      end
      if (c == 4) begin
        chk("p1_addr2", imem_addr, 32'h6000_0008);
        chk("p1_inst_pc1", inst_pc, 32'h6000_0004);
        chk("p1_inst1", inst, 32'h3A5A_5A5E);
      end
      advance();
    end

    // Back-pressure fills the buffer, then a one-cycle ready re-opens issue
    do_reset();
    inst_ready = 1'b0; n_iss = 0;
    for (int c = 0; c < 14; c++) begin
      pre();
      if (imem_rmask == 4'hF) n_iss++;
      if (c == 13) chk("bp_stalled", {28'd0, imem_rmask}, 32'h0);
      advance();
    end
    chk("bp_issue_count", n_iss, 32'd4);
    chk("bp_model_full", mq.size(), 32'd4);
    inst_ready = 1'b1;
    pre();
    chk("bp_reissue_rmask", {28'd0, imem_rmask}, 32'hF);
    chk("bp_reissue_addr", imem_addr, 32'h6000_0010);
    chk("bp_head_pc", inst_pc, 32'h6000_0000);
    advance();
    inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();

    // Reset while waiting with two entries buffered
    do_reset();
    inst_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) set_lat(3, 3);
      step();
    end
    rst = 1'b1;
    pre();
    chk("rstw_model_fill", mq.size(), 32'd2);
    advance();
    rst = 1'b0;
    set_lat(0, 0);
    pre();
    chk("rstw_valid", {31'd0, inst_valid}, 32'h0);
    chk("rstw_addr", imem_addr, 32'h6000_0000);
    chk("rstw_rmask", {28'd0, imem_rmask}, 32'hF);
    advance();

    // Redirect while waiting: stale DEADBEEF response is dropped
    do_reset();
    inst_ready = 1'b0;
    set_lat(2, 2);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h6000_1002;
    step();
    redirect_valid = 1'b0;
    pre();
    chk("rdw_valid_a", {31'd0, inst_valid}, 32'h0);
    chk("rdw_rmask_a", {28'd0, imem_rmask}, 32'h0);
    advance();
    force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    pre();
    chk("rdw_stale_resp", {31'd0, imem_resp}, 32'h1);
    set_lat(0, 0);
    advance();
    force_en = 1'b0;
    pre();
    chk("rdw_valid_b", {31'd0, inst_valid}, 32'h0);
    chk("rdw_rmask_b", {28'd0, imem_rmask}, 32'hF);
    chk("rdw_addr", imem_addr, 32'h6000_1000);
    advance();
    step();
    pre();
    chk("rdw_inst_pc", inst_pc, 32'h6000_1000);
    chk("rdw_inst", inst, 32'h3A5A_4A5A);
    advance();

    // Redirect with three buffered entries and a pop in the same cycle
    do_reset();
    inst_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h6000_2000; inst_ready = 1'b1;
    pre();
    chk("rdf_model_cnt", mq.size(), 32'd3);
    chk("rdf_valid_before", {31'd0, inst_valid}, 32'h1);
    advance();
    redirect_valid = 1'b0;
    pre();
    chk("rdf_valid_after", {31'd0, inst_valid}, 32'h0);
    chk("rdf_addr", imem_addr, 32'h6000_2000);
    chk("rdf_rmask", {28'd0, imem_rmask}, 32'hF);
    advance();
    step();
    pre();
    chk("rdf_inst_pc", inst_pc, 32'h6000_2000);
    advance();

    // Fetch PC wraps from FFFF_FFFC to 0
    do_reset();
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    pre();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    advance();
    step();
    pre();
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    chk("wrap_rmask1", {28'd0, imem_rmask}, 32'hF);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    advance();

    // Randomized traffic
    set_lat(0, 4);
    spur_en = 1'b1; rand_data = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      inst_ready     = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
